phy_tx_lane_scheduler: RTL and testbench

- Clk_4f-domain scheduler for the PHY TX path. It shares the single byte-wide serializer input between four lane FIFOs using round-robin with a burst limit.
- Sequences the link: after enable it sends a COM (0xBC) training sequence, then fills gaps with IDL (0x7C) and interleaves lane data when lanes request.
- Sits between the per-lane first-word-fall-through (FWFT) FIFOs and the 8-to-1 serializer. The serializer runs on clk_32f, so it consumes exactly one byte per clk_4f when tx_ready is high.

---
 rtl/phy_tx_pkg.sv | 26 ++
 rtl/phy_tx_lane_scheduler_if.sv | 26 ++
 rtl/phy_tx_lane_scheduler_rr_arbiter4.sv | 40 ++++
 rtl/phy_tx_lane_scheduler.sv | 137 +++++++++++++
 tb/tb_phy_tx_lane_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/phy_tx_pkg.sv
// Shared PHY TX definitions: link symbols, link state encoding and common widths.
// The serializer and the RX symbol detector use this package as well.
package phy_tx_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned SYM_W     = 8;

  typedef logic [SYM_W-1:0] sym_t;
  typedef logic [1:0]       lane_t;

  localparam sym_t COM_SYM = 8'hBC;
  localparam sym_t IDL_SYM = 8'h7C;

  typedef enum logic [1:0] {
    ST_RESET  = 2'b00,
    ST_TRAIN  = 2'b01,
    ST_IDLE   = 2'b10,
    ST_ACTIVE = 2'b11
  } tx_state_e;

  // Counter width for a count of n values, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phy_tx_lane_scheduler_if.sv
// Lane FIFO heads and serializer byte port shared by the TX lane scheduler.
interface phy_tx_lane_scheduler_if;
  import phy_tx_pkg::*;

  logic  tx_ready;
  logic  valid0, valid1, valid2, valid3;
  sym_t  data_in0, data_in1, data_in2, data_in3;
  logic  [NUM_LANES-1:0] pop;
  sym_t  data_out;
  logic  valid_out;
  logic  k_out;
  lane_t lane_id;

  modport master (
    input  tx_ready, valid0, valid1, valid2, valid3,
           data_in0, data_in1, data_in2, data_in3,
    output pop, data_out, valid_out, k_out, lane_id
  );

  modport slave (
    output tx_ready, valid0, valid1, valid2, valid3,
           data_in0, data_in1, data_in2, data_in3,
    input  pop, data_out, valid_out, k_out, lane_id
  );

endinterface

// File: rtl/phy_tx_lane_scheduler_rr_arbiter4.sv
// Four-way round-robin lane selector with a burst limit on the current lane.
// Purely combinational; the scheduler owns cur and burst_cnt.
module rr_arbiter4
  import phy_tx_pkg::*;
#(
  parameter int unsigned BURST_MAX = 4,
  localparam int unsigned BW = $clog2(BURST_MAX + 1)
) (
  input  logic [NUM_LANES-1:0] valid,
  input  lane_t                cur,
  input  logic [BW-1:0]        burst_cnt,
  output logic                 grant_c,
  output lane_t                lane_c,
  output logic [BW-1:0]        burst_next_c
);

  lane_t idx;

  // A zero burst_cnt means no burst is in progress, so the search always runs.
  always_comb begin
    grant_c      = 1'b0;
    lane_c       = cur;
    burst_next_c = BW'(1);
    idx          = cur;
    if (valid[cur] && (burst_cnt != '0) && (burst_cnt < BW'(BURST_MAX))) begin
      grant_c      = 1'b1;
      burst_next_c = burst_cnt + BW'(1);
    end else begin
      // Walk cur+4 .. cur+1 so the nearest lane after cur wins last.
      for (int k = 4; k >= 1; k--) begin
        idx = cur + 2'(k);
        if (valid[idx]) begin
          grant_c = 1'b1;
          lane_c  = idx;
        end
      end
    end
  end

endmodule

// File: rtl/phy_tx_lane_scheduler.sv
// Clk_4f TX scheduler: COM training after enable, then IDL fill interleaved with
// round-robin lane data onto the single serializer byte input.
module phy_tx_lane_scheduler
  import phy_tx_pkg::*;
#(
  parameter int unsigned NUM_COM   = 4,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic                    clk_4f,
  input  logic                    default_values,
  input  logic                    enable,
  phy_tx_lane_scheduler_if.master bus,
  output logic [1:0]              state,
  output logic                    active
);

  localparam int unsigned BW = $clog2(BURST_MAX + 1);
  localparam int unsigned CW = cnt_w(NUM_COM);
  localparam logic [CW-1:0] COM_LAST = CW'(NUM_COM - 1);

  tx_state_e            state_q, state_d;
  logic [CW-1:0]        com_q, com_d;
  logic [BW-1:0]        burst_q, burst_d, burst_next_c;
  lane_t                cur_q, cur_d, lane_q, lane_d, sel_c;
  sym_t                 data_q, data_d, sel_data_c;
  logic                 valid_q, valid_d, k_q, k_d, active_q, active_d;
  logic                 grant_c;
  logic [NUM_LANES-1:0] pop_c, lane_valid_c;

  assign lane_valid_c = {bus.valid3, bus.valid2, bus.valid1, bus.valid0};

  rr_arbiter4 #(.BURST_MAX(BURST_MAX)) u_arb (
    .valid        (lane_valid_c),
    .cur          (cur_q),
    .burst_cnt    (burst_q),
    .grant_c      (grant_c),
    .lane_c       (sel_c),
    .burst_next_c (burst_next_c)
  );

  always_comb begin
    sel_data_c = bus.data_in0;
    case (sel_c)
      2'd1:    sel_data_c = bus.data_in1;
      2'd2:    sel_data_c = bus.data_in2;
      2'd3:    sel_data_c = bus.data_in3;
      default: sel_data_c = bus.data_in0;
    endcase
  end

  // Next state; tx_ready low freezes everything, enable low overrides that.
  always_comb begin
    state_d = state_q;
    com_d   = com_q;
    burst_d = burst_q;
    cur_d   = cur_q;
    data_d  = data_q;
    valid_d = valid_q;
    k_d     = k_q;
    lane_d  = lane_q;
    pop_c   = '0;
    if (!enable) begin
      state_d = ST_RESET;
      com_d   = '0;
      burst_d = '0;
      cur_d   = '0;
      data_d  = '0;
      valid_d = 1'b0;
      k_d     = 1'b0;
      lane_d  = '0;
    end else if (bus.tx_ready) begin
      unique case (state_q)
        ST_RESET: state_d = ST_TRAIN;
        ST_TRAIN: begin
          data_d  = COM_SYM;
          k_d     = 1'b1;
          valid_d = 1'b0;
          if (com_q == COM_LAST) state_d = ST_IDLE;
          else                   com_d   = com_q + CW'(1);
        end
        ST_IDLE, ST_ACTIVE: begin
          if (grant_c) begin
            pop_c   = 4'b0001 << sel_c;
            data_d  = sel_data_c;
            valid_d = 1'b1;
            k_d     = 1'b0;
            lane_d  = sel_c;
            cur_d   = sel_c;
            burst_d = burst_next_c;
            state_d = ST_ACTIVE;
          end else begin
            data_d  = IDL_SYM;
            valid_d = 1'b0;
            k_d     = 1'b1;
            burst_d = '0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_RESET;
      endcase
    end
    active_d = (state_d == ST_IDLE) || (state_d == ST_ACTIVE);
  end

  always_ff @(posedge clk_4f or posedge default_values) begin
    if (default_values) begin
      state_q  <= ST_RESET;
      com_q    <= '0;
      burst_q  <= '0;
      cur_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      k_q      <= 1'b0;
      lane_q   <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      com_q    <= com_d;
      burst_q  <= burst_d;
      cur_q    <= cur_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      k_q      <= k_d;
      lane_q   <= lane_d;
      active_q <= active_d;
    end
  end

  assign bus.pop       = pop_c;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.k_out     = k_q;
  assign bus.lane_id   = lane_q;
  assign state         = state_q;
  assign active        = active_q;

endmodule

// File: tb/tb_phy_tx_lane_scheduler.sv
// Bench for phy_tx_lane_scheduler: queue-based lane FIFOs, a link-level model
// checked every cycle, and literal expectations for the directed scenarios.
module tb_phy_tx_lane_scheduler;

  localparam int NUM_COM   = 4;
  localparam int BURST_MAX = 4;

  logic       clk_4f = 1'b0;
  logic       default_values = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] state;
  logic       active;

  phy_tx_lane_scheduler_if bus ();

  phy_tx_lane_scheduler #(.NUM_COM(NUM_COM), .BURST_MAX(BURST_MAX)) dut (
    .clk_4f         (clk_4f),
    .default_values (default_values),
    .enable         (enable),
    .bus            (bus),
    .state          (state),
    .active         (active)
  );

  always #5 clk_4f = ~clk_4f;

  int errors = 0;
  int checks = 0;

  logic [7:0] fifo [4][$];
  logic [3:0] pop_seen = '0;
  bit         rec = 1'b0;
  int         gq [$];

  typedef struct {
    int         st;
    int         com;
    int         cur;
    int         burst;
    logic [7:0] data;
    logic       valid;
    logic       k;
    int         lane;
  } mdl_t;

  mdl_t m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] vvec();
    return {bus.valid3, bus.valid2, bus.valid1, bus.valid0};
  endfunction

  function automatic logic [7:0] lane_data(input int l);
    case (l)
      1:       return bus.data_in1;
      2:       return bus.data_in2;
      3:       return bus.data_in3;
      default: return bus.data_in0;
    endcase
  endfunction

  function automatic mdl_t mdl_rst();
    mdl_t r;
    r.st = 0; r.com = 0; r.cur = 0; r.burst = 0;
    r.data = 8'h00; r.valid = 1'b0; r.k = 1'b0; r.lane = 0;
    return r;
  endfunction

  // The lane granted last keeps going only while the link is mid-burst.
  function automatic bit holds(input logic [3:0] v);
    return (m.st == 3) && v[m.cur] && (m.burst < BURST_MAX);
  endfunction

  function automatic int pick(input logic [3:0] v);
    if (holds(v)) return m.cur;
    for (int k = 1; k <= 4; k++)
      if (v[(m.cur + k) % 4]) return (m.cur + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] exp_pop();
    int l;
    exp_pop = 4'b0000;
    if (enable && bus.tx_ready && (m.st >= 2)) begin
      l = pick(vvec());
      if (l >= 0) exp_pop = 4'(1 << l);
    end
  endfunction

  task automatic refresh();
    bus.valid0   = fifo[0].size() != 0;
    bus.valid1   = fifo[1].size() != 0;
    bus.valid2   = fifo[2].size() != 0;
    bus.valid3   = fifo[3].size() != 0;
    bus.data_in0 = (fifo[0].size() != 0) ? fifo[0][0] : 8'h00;
    bus.data_in1 = (fifo[1].size() != 0) ? fifo[1][0] : 8'h00;
    bus.data_in2 = (fifo[2].size() != 0) ? fifo[2][0] : 8'h00;
    bus.data_in3 = (fifo[3].size() != 0) ? fifo[3][0] : 8'h00;
  endtask

  task automatic tick();
    @(posedge clk_4f);
    #1;
    for (int i = 0; i < 4; i++)
      if (pop_seen[i] && (fifo[i].size() != 0)) void'(fifo[i].pop_front());
    refresh();
  endtask

  // Link model: advances on every accepted byte time.
  initial begin
    logic [3:0] v;
    int         l;
    bit         h;
    m = mdl_rst();
    forever begin
      @(posedge clk_4f or posedge default_values);
      if (default_values || !enable) begin
        m = mdl_rst();
      end else if (bus.tx_ready) begin
        case (m.st)
          0: m.st = 1;
          1: begin
            m.data = 8'hBC; m.k = 1'b1; m.valid = 1'b0;
            if (m.com == NUM_COM - 1) m.st = 2;
            else                      m.com++;
          end
          default: begin
            v = vvec();
            h = holds(v);
            l = pick(v);
            if (l >= 0) begin
              m.burst = h ? m.burst + 1 : 1;
              m.cur   = l;
              m.lane  = l;
              m.data  = lane_data(l);
              m.valid = 1'b1;
              m.k     = 1'b0;
              m.st    = 3;
            end else begin
              m.data = 8'h7C; m.valid = 1'b0; m.k = 1'b1; m.st = 2;
            end
          end
        endcase
      end
    end
  end

  // Compare DUT against the model mid-cycle, when inputs and outputs are settled.
  initial begin
    forever begin
      @(negedge clk_4f);
      pop_seen = bus.pop;
      chk("pop", 32'(bus.pop), 32'(exp_pop()));
      chk("pop_onehot", 32'($onehot0(bus.pop)), 32'(1));
      for (int i = 0; i < 4; i++)
        if (bus.pop[i]) chk("pop_lane_valid", 32'(vvec()), 32'(vvec() | 4'(1 << i)));
      chk("data_out", 32'(bus.data_out), 32'(m.data));
      chk("valid_out", 32'(bus.valid_out), 32'(m.valid));
      chk("k_out", 32'(bus.k_out), 32'(m.k));
      chk("state", 32'(state), 32'(m.st));
      chk("active", 32'(active), 32'(m.st >= 2));
      if (m.valid) chk("lane_id", 32'(bus.lane_id), 32'(m.lane));
      if (rec && (bus.pop != 4'b0000) && (gq.size() < 16)) begin
        for (int i = 0; i < 4; i++) if (bus.pop[i]) gq.push_back(i);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order [16];
    int n;
    exp_order = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0, 0, 0, 0};
    bus.tx_ready = 1'b0;
    refresh();
    #1 default_values = 1'b1;
    #12 default_values = 1'b0;
    tick();
    chk("rst_state", 32'(state), 32'(0));
    chk("rst_data", 32'(bus.data_out), 32'(0));
    chk("rst_k", 32'(bus.k_out), 32'(0));

    // Training after enable: 4 x BC, then IDL.
    enable = 1'b1; bus.tx_ready = 1'b1;
    tick();
    chk("train_enter", 32'(state), 32'(1));
    chk("train_first_data", 32'(bus.data_out), 32'(0));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("train_com", 32'(bus.data_out), 32'(8'hBC));
      chk("train_k", 32'(bus.k_out), 32'(1));
    end
    chk("idle_after_train", 32'(state), 32'(2));
    chk("active_after_train", 32'(active), 32'(1));
    tick();
    chk("idle_fill", 32'(bus.data_out), 32'(8'h7C));

    // Single lane 2 stream.
    fifo[2].push_back(8'h11); fifo[2].push_back(8'h22); fifo[2].push_back(8'h33);
    refresh();
    tick();
    chk("l2_b0", 32'(bus.data_out), 32'(8'h11));
    chk("l2_lane", 32'(bus.lane_id), 32'(2));
    chk("l2_state", 32'(state), 32'(3));
    tick();
    chk("l2_b1", 32'(bus.data_out), 32'(8'h22));
    tick();
    chk("l2_b2", 32'(bus.data_out), 32'(8'h33));
    tick();
    chk("l2_end_idl", 32'(bus.data_out), 32'(8'h7C));
    chk("l2_end_state", 32'(state), 32'(2));

    // Enable dropped while ACTIVE, then a full retrain.
    fifo[1].push_back(8'hA1); fifo[1].push_back(8'hA2); fifo[1].push_back(8'hA3);
    refresh();
    tick();
    chk("en_active", 32'(state), 32'(3));
    enable = 1'b0;
    tick();
    chk("en_drop_state", 32'(state), 32'(0));
    chk("en_drop_data", 32'(bus.data_out), 32'(0));
    chk("en_drop_valid", 32'(bus.valid_out), 32'(0));
    fifo[1].delete();
    refresh();
    enable = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("retrain_com", 32'(bus.data_out), 32'(8'hBC));
    end
    tick();
    chk("retrain_idl", 32'(bus.data_out), 32'(8'h7C));

    // All lanes requesting from cur=0, with a tx_ready stall mid-burst.
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 6; k++) fifo[i].push_back(8'(((i + 1) << 4) | k));
    gq.delete();
    rec = 1'b1;
    refresh();
    tick();
    tick();
    chk("stall_pre_data", 32'(bus.data_out), 32'(8'h21));
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_data", 32'(bus.data_out), 32'(8'h21));
      chk("stall_state", 32'(state), 32'(3));
    end
    bus.tx_ready = 1'b1;
    n = 0;
    while ((gq.size() < 16) && (n < 40)) begin
      tick();
      n++;
    end
    chk("grant_count", 32'(gq.size()), 32'(16));
    for (int i = 0; i < 16; i++)
      if (i < gq.size()) chk("grant_order", 32'(gq[i]), 32'(exp_order[i]));
    rec = 1'b0;
    n = 0;
    while (((fifo[0].size() + fifo[1].size() + fifo[2].size() + fifo[3].size()) != 0 || state != 2'd2)
           && (n < 30)) begin
      tick();
      n++;
    end
    chk("drain_state", 32'(state), 32'(2));
    chk("drain_idl", 32'(bus.data_out), 32'(8'h7C));

    // Asynchronous reset pulse between edges while ACTIVE.
    for (int k = 0; k < 4; k++) fifo[3].push_back(8'hD0 + 8'(k));
    refresh();
    tick();
    tick();
    chk("ar_active", 32'(state), 32'(3));
    #2 default_values = 1'b1;
    #1;
    chk("ar_data", 32'(bus.data_out), 32'(0));
    chk("ar_valid", 32'(bus.valid_out), 32'(0));
    chk("ar_k", 32'(bus.k_out), 32'(0));
    chk("ar_state", 32'(state), 32'(0));
    chk("ar_active_flag", 32'(active), 32'(0));
    #3 default_values = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("ar_recover_state", 32'(state), 32'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
